sensor_request_scheduler: RTL and testbench

Sequences all traffic into the sensor decoder. It accepts decoded client requests and executes one-shot reads on the sensor decoder. It keeps a small table of continuous-monitoring subscriptions and polls them round-robin on a fixed period, with one-shot client reads taking priority. It sits between the request handler and the sensor decoder / response handler, and returns every result with a source tag and a flow-controlled handshake.

---
 rtl/sensor_request_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_sensor_request_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_request_scheduler.sv
// Request scheduler in front of the sensor decoder: one-shot client reads plus round-robin
// monitoring polls. Define SCHED_TIMEOUT_EN to build in the transaction watchdog.
`timescale 1ns/1ps
module sensor_request_scheduler #(
  parameter int unsigned N_SLOTS        = 4,
  parameter int unsigned POLL_PERIOD    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_code,
  input  logic [4:0] req_device,
  output logic       sd_enable,
  output logic [4:0] sd_device,
  output logic [7:0] sd_request,
  input  logic       sd_finished,
  input  logic [7:0] sd_response,
  input  logic [7:0] sd_response_code,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [7:0] rsp_code,
  output logic       rsp_source
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  localparam logic [7:0] CODE_START_TEMP = 8'h05;
  localparam logic [7:0] CODE_START_HUM  = 8'h06;
  localparam logic [7:0] CODE_STOP_TEMP  = 8'h07;
  localparam logic [7:0] CODE_STOP_HUM   = 8'h08;
  localparam logic [7:0] CODE_READ_TEMP  = 8'h03;
  localparam logic [7:0] CODE_READ_HUM   = 8'h04;
  localparam logic [7:0] ACK_START       = 8'h0A;
  localparam logic [7:0] ACK_STOP        = 8'h0B;
  localparam logic [7:0] ERR_FULL        = 8'hE1;
  localparam logic [7:0] ERR_NO_ENTRY    = 8'hE2;

  localparam int unsigned IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int unsigned PT_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  logic [1:0]         state;
  logic               pend_valid;
  logic [7:0]         pend_code;
  logic [4:0]         pend_device;
  logic [N_SLOTS-1:0] slot_valid;
  logic [4:0]         slot_device [N_SLOTS];
  logic [N_SLOTS-1:0] slot_kind;
  logic [IDX_W-1:0]   last_idx;
  logic [PT_W-1:0]    poll_cnt;
  logic               poll_due;

  logic               is_start;
  logic               is_stop;
  logic               cmd_kind;
  logic               match_found;
  logic [IDX_W-1:0]   match_idx;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               poll_found;
  logic [IDX_W-1:0]   poll_idx;
  logic               any_valid;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  assign req_ready = !pend_valid;
  assign sd_enable = (state == S_ISSUE);
  assign rsp_valid = (state == S_RESPOND);
  assign any_valid = |slot_valid;

  always_comb begin
    is_start = (pend_code == CODE_START_TEMP) || (pend_code == CODE_START_HUM);
    is_stop  = (pend_code == CODE_STOP_TEMP) || (pend_code == CODE_STOP_HUM);
    cmd_kind = (pend_code == CODE_START_HUM) || (pend_code == CODE_STOP_HUM);
  end

  // Lowest-index matching entry and lowest-index free slot for the pending command.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (!match_found && slot_valid[IDX_W'(i)] &&
          (slot_device[IDX_W'(i)] == pend_device) && (slot_kind[IDX_W'(i)] == cmd_kind)) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!free_found && !slot_valid[IDX_W'(i)]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Round-robin: first valid slot strictly after the last served one, wrapping back to it.
  always_comb begin
    poll_found = 1'b0;
    poll_idx   = '0;
    for (int unsigned i = 1; i <= N_SLOTS; i++) begin
      if (!poll_found && slot_valid[IDX_W'((32'(last_idx) + i) % N_SLOTS)]) begin
        poll_found = 1'b1;
        poll_idx   = IDX_W'((32'(last_idx) + i) % N_SLOTS);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pend_valid  <= 1'b0;
      pend_code   <= '0;
      pend_device <= '0;
      slot_valid  <= '0;
      slot_kind   <= '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) slot_device[i] <= '0;
      last_idx    <= IDX_W'(N_SLOTS - 1);
      poll_cnt    <= '0;
      poll_due    <= 1'b0;
      sd_device   <= '0;
      sd_request  <= '0;
      rsp_data    <= '0;
      rsp_code    <= '0;
      rsp_source  <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      if (req_valid && req_ready) begin
        pend_valid  <= 1'b1;
        pend_code   <= req_code;
        pend_device <= req_device;
      end

      case (state)
        S_IDLE: begin
          if (pend_valid) begin
            pend_valid <= 1'b0;
            if (is_start || is_stop) begin
              rsp_data   <= {3'b000, pend_device};
              rsp_source <= 1'b0;
              state      <= S_RESPOND;
              if (is_start) begin
                if (match_found) begin
                  rsp_code <= ACK_START;
                end else if (free_found) begin
                  slot_valid[free_idx]  <= 1'b1;
                  slot_device[free_idx] <= pend_device;
                  slot_kind[free_idx]   <= cmd_kind;
                  rsp_code              <= ACK_START;
                end else begin
                  rsp_code <= ERR_FULL;
                end
              end else if (match_found) begin
                slot_valid[match_idx] <= 1'b0;
                rsp_code              <= ACK_STOP;
              end else begin
                rsp_code <= ERR_NO_ENTRY;
              end
            end else begin
              sd_device  <= pend_device;
              sd_request <= pend_code;
              rsp_source <= 1'b0;
              state      <= S_ISSUE;
            end
          end else if (poll_due && poll_found) begin
            poll_due   <= 1'b0;
            last_idx   <= poll_idx;
            sd_device  <= slot_device[poll_idx];
            sd_request <= slot_kind[poll_idx] ? CODE_READ_HUM : CODE_READ_TEMP;
            rsp_source <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef SCHED_TIMEOUT_EN
          wd_cnt <= WD_W'(TIMEOUT_CYCLES);
`endif
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (sd_finished) begin
            rsp_data <= sd_response;
            rsp_code <= sd_response_code;
            state    <= S_RESPOND;
          end
`ifdef SCHED_TIMEOUT_EN
          else if (wd_cnt == WD_W'(1)) begin
            rsp_data <= 8'h00;
            rsp_code <= 8'hEF;
            state    <= S_RESPOND;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
`endif
        end
        default: begin
          if (rsp_ready) state <= S_IDLE;
        end
      endcase

      // Timer placed after the FSM so a wrap coinciding with a poll issue re-arms poll_due.
      if (poll_cnt == PT_W'(POLL_PERIOD - 1)) begin
        poll_cnt <= '0;
        if (any_valid) poll_due <= 1'b1;
      end else begin
        poll_cnt <= poll_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sensor_request_scheduler.sv
// Directed bench for sensor_request_scheduler: one-shot reads, table commands, polling,
// client priority, watchdog (either build of SCHED_TIMEOUT_EN) and async reset.
`timescale 1ns/1ps
module tb_sensor_request_scheduler;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_code = '0;
  logic [4:0] req_device = '0;
  logic       sd_enable;
  logic [4:0] sd_device;
  logic [7:0] sd_request;
  logic       sd_finished = 1'b0;
  logic [7:0] sd_response = '0;
  logic [7:0] sd_response_code = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [7:0] rsp_code;
  logic       rsp_source;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_count = 0;

  sensor_request_scheduler #(
    .N_SLOTS(4),
    .POLL_PERIOD(100),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code), .req_device(req_device),
    .sd_enable(sd_enable), .sd_device(sd_device), .sd_request(sd_request),
    .sd_finished(sd_finished), .sd_response(sd_response), .sd_response_code(sd_response_code),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_code(rsp_code),
    .rsp_source(rsp_source)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (sd_enable) en_count <= en_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; sd_finished = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic send_req(input logic [7:0] code, input logic [4:0] dev);
    @(posedge clock); #1;
    req_valid = 1'b1; req_code = code; req_device = dev;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input logic [7:0] d, input logic [7:0] c, input logic s, input string tag);
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_data"}, rsp_data, d);
    check({tag, "_code"}, rsp_code, c);
    check({tag, "_src"}, rsp_source, s);
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] code, input logic [4:0] dev, input logic [7:0] exp_code,
                        input string tag);
    send_req(code, dev);
    @(posedge clock); #1;
    expect_rsp({3'b000, dev}, exp_code, 1'b0, tag);
    accept_rsp();
  endtask

  task automatic wait_enable(input int max_cyc, input string tag, output int at);
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clock); #1;
      if (sd_enable) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({tag, "_enable"}, sd_enable, 1'b1);
  endtask

  task automatic dec_reply(input int delay, input logic [7:0] d, input logic [7:0] c);
    repeat (delay) @(posedge clock);
    #1;
    sd_finished = 1'b1; sd_response = d; sd_response_code = c;
    @(posedge clock); #1;
    sd_finished = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t1, t2, t3, tw, en0;

    // Reset values
    reset_n = 1'b0;
    #3;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_sd_enable", sd_enable, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_sd_device", sd_device, 5'd0);
    check("rst_sd_request", sd_request, 8'h00);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rsp_code", rsp_code, 8'h00);
    check("rst_rsp_source", rsp_source, 1'b0);
    do_reset();

    // sd_finished while idle is ignored
    @(posedge clock); #1; sd_finished = 1'b1; sd_response = 8'h77;
    @(posedge clock); #1; sd_finished = 1'b0;
    @(posedge clock); #1;
    check("idle_fin_ignored", rsp_valid, 1'b0);

    // One-shot read, code 0x01 device 3
    en0 = en_count;
    send_req(8'h01, 5'd3);
    check("os_ready_low", req_ready, 1'b0);
    check("os_en_early", sd_enable, 1'b0);
    @(posedge clock); #1;
    check("os_en", sd_enable, 1'b1);
    check("os_dev", sd_device, 5'd3);
    check("os_req", sd_request, 8'h01);
    dec_reply(10, 8'h1B, 8'h00);
    expect_rsp(8'h1B, 8'h00, 1'b0, "os");
    accept_rsp();
    check("os_one_enable", en_count - en0, 1);

    // Table fill, full, duplicate, stop miss/hit, refill
    do_reset();
    en0 = en_count;
    do_cmd(8'h05, 5'd1, 8'h0A, "st1");
    do_cmd(8'h05, 5'd2, 8'h0A, "st2");
    do_cmd(8'h05, 5'd3, 8'h0A, "st3");
    do_cmd(8'h05, 5'd4, 8'h0A, "st4");
    do_cmd(8'h05, 5'd5, 8'hE1, "full");
    do_cmd(8'h05, 5'd1, 8'h0A, "dup");
    do_cmd(8'h08, 5'd1, 8'hE2, "stop_miss");
    do_cmd(8'h07, 5'd1, 8'h0B, "stop_hit");
    do_cmd(8'h05, 5'd5, 8'h0A, "refill");
    check("tbl_no_enable", en_count - en0, 0);

    // Round-robin polling every 100 cycles
    do_reset();
    do_cmd(8'h05, 5'd2, 8'h0A, "mon_t");
    do_cmd(8'h06, 5'd7, 8'h0A, "mon_h");
    wait_enable(150, "p1", t1);
    check("p1_dev", sd_device, 5'd2);
    check("p1_req", sd_request, 8'h03);
    dec_reply(3, 8'h21, 8'h00);
    expect_rsp(8'h21, 8'h00, 1'b1, "p1");
    accept_rsp();
    wait_enable(150, "p2", t2);
    check("p2_dev", sd_device, 5'd7);
    check("p2_req", sd_request, 8'h04);
    check("p2_period", t2 - t1, 100);
    dec_reply(3, 8'h40, 8'h00);
    expect_rsp(8'h40, 8'h00, 1'b1, "p2");
    accept_rsp();
    wait_enable(150, "p3", t3);
    check("p3_dev", sd_device, 5'd2);
    check("p3_period", t3 - t2, 100);
    dec_reply(3, 8'h22, 8'h00);

    // Client read pending while poll_due rises behind a stalled response
    send_req(8'h01, 5'd9);
    check("pr_ready_low", req_ready, 1'b0);
    while (cyc < t3 + 105) begin
      @(posedge clock); #1;
    end
    check("pr_ready_held", req_ready, 1'b0);
    expect_rsp(8'h22, 8'h00, 1'b1, "p3");
    accept_rsp();
    @(posedge clock); #1;
    check("pr_cli_en", sd_enable, 1'b1);
    check("pr_cli_dev", sd_device, 5'd9);
    check("pr_cli_req", sd_request, 8'h01);
    dec_reply(2, 8'h99, 8'h01);
    expect_rsp(8'h99, 8'h01, 1'b0, "pr_cli");
    accept_rsp();
    @(posedge clock); #1;
    check("pr_poll_en", sd_enable, 1'b1);
    check("pr_poll_dev", sd_device, 5'd7);
    check("pr_poll_req", sd_request, 8'h04);
    dec_reply(2, 8'h41, 8'h00);
    expect_rsp(8'h41, 8'h00, 1'b1, "pr_poll");
    accept_rsp();

    // Watchdog
    do_reset();
    send_req(8'h01, 5'd4);
    wait_enable(5, "wd", tw);
`ifdef SCHED_TIMEOUT_EN
    repeat (50) @(posedge clock);
    #1;
    check("wd_early", rsp_valid, 1'b0);
    @(posedge clock); #1;
    expect_rsp(8'h00, 8'hEF, 1'b0, "wd");
`else
    repeat (200) @(posedge clock);
    #1;
    check("wd_hold", rsp_valid, 1'b0);
    check("wd_no_reissue", sd_enable, 1'b0);
    dec_reply(0, 8'h55, 8'h00);
    expect_rsp(8'h55, 8'h00, 1'b0, "wd_late");
`endif
    accept_rsp();

    // Backpressure then asynchronous reset mid-RESPOND
    do_reset();
    send_req(8'h02, 5'd6);
    wait_enable(5, "bp_os", tw);
    dec_reply(2, 8'h10, 8'h00);
    expect_rsp(8'h10, 8'h00, 1'b0, "bp_os");
    accept_rsp();
    send_req(8'h06, 5'd3);
    @(posedge clock); #1;
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_code", rsp_code, 8'h0A);
      check("bp_data", rsp_data, 8'h03);
      @(posedge clock); #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_rsp_valid", rsp_valid, 1'b0);
    check("ar_rsp_code", rsp_code, 8'h00);
    check("ar_rsp_data", rsp_data, 8'h00);
    check("ar_sd_device", sd_device, 5'd0);
    check("ar_sd_request", sd_request, 8'h00);
    check("ar_req_ready", req_ready, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    do_cmd(8'h08, 5'd3, 8'hE2, "ar_tbl_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
